// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port VRAM between the video fetcher (fixed priority)
// and the register bus, with a starvation guard and fixed-latency registered responses.
module vram_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 600,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_gnt,
  output logic [DATA_W-1:0]     vid_rdata,
  output logic                  vid_rvalid,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_W-1:0]     bus_addr,
  input  logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W/8-1:0]   bus_wstrb,
  output logic                  bus_gnt,
  output logic                  bus_done,
  output logic [DATA_W-1:0]     bus_rdata,
  output logic                  bus_err,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  typedef enum logic {ST_VID_PRI, ST_BUS_FORCE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic vid_oor, bus_oor, issue_d, rd_d;
  logic [DATA_W/8-1:0] mem_we_d;
  logic [RD_LAT:0] tag_vld_q, tag_bus_q, tag_err_q, tag_rd_q;
  logic mem_en_q, vid_rvalid_q, bus_done_q, bus_err_q;
  logic [DATA_W/8-1:0] mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, vid_rdata_q, bus_rdata_q;
  assign bus_gnt = bus_req & ((state_q == ST_BUS_FORCE) | ~vid_req);
  assign vid_gnt = vid_req & ~bus_gnt;
  always_comb begin
    vid_oor  = {1'b0, vid_addr} >= DEPTH_W;
    bus_oor  = {1'b0, bus_addr} >= DEPTH_W;
    issue_d  = vid_gnt ? ~vid_oor : bus_gnt & ~bus_oor & (~bus_we | (|bus_wstrb));
    rd_d     = issue_d & ~(bus_gnt & bus_we);
    mem_we_d = (bus_gnt & bus_we & ~bus_oor) ? bus_wstrb : '0;
    wait_d   = (~bus_req | bus_gnt) ? '0 : (wait_q == LIM ? LIM : wait_q + 1'b1);
    state_d  = (bus_req & ~bus_gnt & (wait_q == LIM - 1'b1)) ? ST_BUS_FORCE : ST_VID_PRI;
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_VID_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  // Tags travel alongside the BRAM access so each response knows its owner and outcome.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag_vld_q    <= '0;
      tag_bus_q    <= '0;
      tag_err_q    <= '0;
      tag_rd_q     <= '0;
      vid_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      bus_done_q   <= 1'b0;
      bus_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      mem_en_q     <= issue_d;
      mem_we_q     <= mem_we_d;
      if (issue_d) mem_addr_q <= vid_gnt ? vid_addr : bus_addr;
      if (|mem_we_d) mem_wdata_q <= bus_wdata;
      tag_vld_q    <= {tag_vld_q[RD_LAT-1:0], vid_gnt | bus_gnt};
      tag_bus_q    <= {tag_bus_q[RD_LAT-1:0], bus_gnt};
      tag_err_q    <= {tag_err_q[RD_LAT-1:0], bus_gnt & bus_oor};
      tag_rd_q     <= {tag_rd_q[RD_LAT-1:0], rd_d};
      vid_rvalid_q <= tag_vld_q[RD_LAT] & ~tag_bus_q[RD_LAT];
      vid_rdata_q  <= (tag_rd_q[RD_LAT] & ~tag_bus_q[RD_LAT]) ? mem_rdata : '0;
      bus_done_q   <= tag_vld_q[RD_LAT] & tag_bus_q[RD_LAT];
      bus_rdata_q  <= (tag_rd_q[RD_LAT] & tag_bus_q[RD_LAT]) ? mem_rdata : '0;
      bus_err_q    <= tag_vld_q[RD_LAT] & tag_bus_q[RD_LAT] & tag_err_q[RD_LAT];
    end
  end
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign bus_done   = bus_done_q;
  assign bus_rdata  = bus_rdata_q;
  assign bus_err    = bus_err_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed scenarios plus a randomized run scored against a
// shadow-memory model of the arbitration and response rules.
module tb_vram_port_arbiter;
  localparam int STARVE = 8;
  localparam int DEPTH = 600;
  logic clk = 1'b0;
  logic rst_n;
  logic vid_req, vid_gnt, vid_rvalid;
  logic [9:0] vid_addr, bus_addr, mem_addr;
  logic [31:0] vid_rdata, bus_wdata, bus_rdata, mem_wdata, mem_rdata;
  logic bus_req, bus_we, bus_gnt, bus_done, bus_err, mem_en;
  logic [3:0] bus_wstrb, mem_we;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] bram [0:1023];
  logic [31:0] shadow [0:1023];
  typedef struct { int due; logic bus; logic [31:0] d; logic e; } rsp_t;
  always #5 clk = ~clk;
  vram_port_arbiter dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_done(bus_done),
    .bus_rdata(bus_rdata), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  // Read-first single-port BRAM, 1-cycle latency
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= bram[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  task automatic bus_op(input logic we, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int lat, output logic en_seen);
    logic g;
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_wstrb = st;
    g = 1'b0; lat = -1; rd = '0; er = 1'b0; en_seen = 1'b0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      if (bus_gnt) g = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus_req = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      en_seen |= mem_en;
      if (bus_done) begin lat = i; rd = bus_rdata; er = bus_err; end
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0; bus_req = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    for (int i = 0; i < 1024; i++) bram[i] <= '0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({vid_gnt, bus_gnt, vid_rvalid, bus_done, bus_err, mem_en} !== 6'b0) begin
      n_bad++; $display("FAIL rst_flags: got %b exp 000000", {vid_gnt, bus_gnt, vid_rvalid, bus_done, bus_err, mem_en});
    end
    n_cmp++;
    if ({vid_rdata, bus_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL rst_rdata: got %h exp 0", {vid_rdata, bus_rdata});
    end
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== 46'h0) begin
      n_bad++; $display("FAIL rst_mem: got %h exp 0", {mem_we, mem_addr, mem_wdata});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_write_read;
    logic [31:0] rd; logic er, en; int lat;
    bus_op(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || er !== 1'b0) begin
      n_bad++; $display("FAIL wr5: got lat=%0d err=%b exp lat=3 err=0", lat, er);
    end
    bus_op(1'b0, 10'd5, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd5: got lat=%0d err=%b data=%h exp lat=3 err=0 data=deadbeef", lat, er, rd);
    end
  endtask
  task automatic test_strobe;
    logic [31:0] rd; logic er, en; int lat;
    bus_op(1'b1, 10'd7, 32'h11223344, 4'hF, rd, er, lat, en);
    bus_op(1'b1, 10'd7, 32'hAABBCCDD, 4'b0101, rd, er, lat, en);
    bus_op(1'b0, 10'd7, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL strobe_rd: got lat=%0d data=%h exp lat=3 data=11bb33dd", lat, rd);
    end
    bus_op(1'b1, 10'd7, 32'hFFFFFFFF, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || er !== 1'b0 || en !== 1'b0) begin
      n_bad++; $display("FAIL zero_strb: got lat=%0d err=%b mem_en=%b exp lat=3 err=0 mem_en=0", lat, er, en);
    end
    bus_op(1'b0, 10'd7, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL zero_strb_rd: got %h exp 11bb33dd", rd);
    end
  endtask
  task automatic test_starve;
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 10'd10; bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'd5;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 9) bus_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus_gnt !== (c == 8)) begin
        n_bad++; $display("FAIL starve_bus_gnt c%0d: got %b exp %b", c, bus_gnt, c == 8);
      end
      n_cmp++;
      if (vid_gnt !== (c != 8)) begin
        n_bad++; $display("FAIL starve_vid_gnt c%0d: got %b exp %b", c, vid_gnt, c != 8);
      end
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_oor;
    logic [31:0] rd; logic er, en; int lat;
    bus_op(1'b0, 10'd600, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || er !== 1'b1 || rd !== 32'h0 || en !== 1'b0) begin
      n_bad++; $display("FAIL oor_rd: got lat=%0d err=%b data=%h mem_en=%b exp 3 1 0 0", lat, er, rd, en);
    end
    bus_op(1'b1, 10'd700, 32'h12345678, 4'hF, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || er !== 1'b1 || en !== 1'b0) begin
      n_bad++; $display("FAIL oor_wr: got lat=%0d err=%b mem_en=%b exp 3 1 0", lat, er, en);
    end
    bus_op(1'b1, 10'd599, 32'hCAFEF00D, 4'hF, rd, er, lat, en);
    bus_op(1'b0, 10'd599, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL last_word: got err=%b data=%h exp err=0 data=cafef00d", er, rd);
    end
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 10'd650;
    @(negedge clk);
    @(posedge clk); #1;
    vid_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (vid_rvalid !== 1'b1 || vid_rdata !== 32'h0) begin
      n_bad++; $display("FAIL vid_oor: got rvalid=%b data=%h exp 1 0", vid_rvalid, vid_rdata);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd; logic er, en; int lat;
    @(posedge clk); #1;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'd5;
    @(negedge clk);
    n_cmp++;
    if (bus_gnt !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_gnt: got %b exp 1", bus_gnt);
    end
    @(posedge clk); #1;
    bus_req = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_addr, bus_done, vid_rvalid} !== 13'h0) begin
      n_bad++; $display("FAIL rstmid_out: got %h exp 0", {mem_en, mem_addr, bus_done, vid_rvalid});
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_done !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_nodone c%0d: got %b exp 0", c, bus_done);
      end
    end
    bus_op(1'b0, 10'd5, 32'h0, 4'h0, rd, er, lat, en);
    n_cmp++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_rd: got lat=%0d data=%h err=%b exp 3 deadbeef 0", lat, rd, er);
    end
  endtask
  task automatic test_video_stream;
    for (int i = 0; i < 80; i++) bram[i] <= pat(i);
    for (int c = 0; c < 87; c++) begin
      @(posedge clk); #1;
      vid_req = (c < 80); vid_addr = 10'(c);
      @(negedge clk);
      n_cmp++;
      if (vid_gnt !== (c < 80) || vid_rvalid !== (c >= 3 && c < 83)) begin
        n_bad++; $display("FAIL stream c%0d: got gnt=%b rvalid=%b exp %b %b", c, vid_gnt, vid_rvalid, c < 80, c >= 3 && c < 83);
      end
      if (c >= 3 && c < 83) begin
        n_cmp++;
        if (vid_rdata !== pat(c - 3)) begin
          n_bad++; $display("FAIL stream_data c%0d: got %h exp %h", c, vid_rdata, pat(c - 3));
        end
      end
    end
  endtask
  task automatic test_random;
    rsp_t q[$];
    rsp_t r;
    int run = 0;
    logic pend = 1'b0, ev, eb, exp_vg, exp_bg, oor;
    for (int i = 0; i < 1024; i++) shadow[i] = bram[i];
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      vid_req = (cyc < 494) && ($urandom_range(0, 9) < 7);
      vid_addr = ($urandom_range(0, 9) == 0) ? 10'(600 + $urandom_range(0, 400)) : 10'($urandom_range(0, 99));
      if (!pend && cyc < 494 && $urandom_range(0, 9) < 4) begin
        pend = 1'b1;
        bus_we = 1'($urandom_range(0, 1));
        bus_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(596, 605)) : 10'($urandom_range(0, 15));
        bus_wdata = $urandom;
        bus_wstrb = 4'($urandom_range(0, 15));
      end
      bus_req = pend;
      @(negedge clk);
      exp_bg = bus_req && (!vid_req || run == STARVE);
      exp_vg = vid_req && !exp_bg;
      n_cmp++;
      if (vid_gnt !== exp_vg || bus_gnt !== exp_bg) begin
        n_bad++; $display("FAIL rnd_gnt c%0d: got vid=%b bus=%b exp vid=%b bus=%b", cyc, vid_gnt, bus_gnt, exp_vg, exp_bg);
      end
      ev = 1'b0; eb = 1'b0; r.d = '0; r.e = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
        r = q.pop_front(); ev = !r.bus; eb = r.bus;
      end
      n_cmp++;
      if (vid_rvalid !== ev || bus_done !== eb) begin
        n_bad++; $display("FAIL rnd_valid c%0d: got rvalid=%b done=%b exp %b %b", cyc, vid_rvalid, bus_done, ev, eb);
      end
      if (ev) begin
        n_cmp++;
        if (vid_rdata !== r.d) begin
          n_bad++; $display("FAIL rnd_vdata c%0d: got %h exp %h", cyc, vid_rdata, r.d);
        end
      end
      if (eb) begin
        n_cmp++;
        if (bus_rdata !== r.d || bus_err !== r.e) begin
          n_bad++; $display("FAIL rnd_bus c%0d: got data=%h err=%b exp %h %b", cyc, bus_rdata, bus_err, r.d, r.e);
        end
      end
      if (exp_vg) q.push_back('{cyc + 3, 1'b0, (vid_addr < DEPTH) ? shadow[vid_addr] : 32'h0, 1'b0});
      if (exp_bg) begin
        oor = (bus_addr >= DEPTH);
        if (bus_we) begin
          if (!oor) for (int b = 0; b < 4; b++) if (bus_wstrb[b]) shadow[bus_addr][8*b +: 8] = bus_wdata[8*b +: 8];
          q.push_back('{cyc + 3, 1'b1, 32'h0, oor});
        end else q.push_back('{cyc + 3, 1'b1, oor ? 32'h0 : shadow[bus_addr], oor});
        pend = 1'b0;
      end
      run = (bus_req && !exp_bg) ? run + 1 : 0;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain: got %0d responses outstanding exp 0", q.size());
    end
    bus_req = 1'b0; vid_req = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_write_read;
    test_strobe;
    test_starve;
    test_oor;
    test_reset_mid;
    test_video_stream;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
